// File: rtl/b_reg_arbiter.sv
// Arbiter/access sequencer sharing the B register among N_REQ requesters.
// Optional: define B_REG_ARB_RR_EN for round-robin; default is fixed priority (lowest index wins).
module b_reg_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DW    = 16
) (
    input  logic                  b_reg_arb_clk,
    input  logic                  b_reg_arb_rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      we,
    input  logic [N_REQ*DW-1:0]   wdata,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      ack,
    output logic [DW-1:0]         rdata,
    output logic                  busy,
    output logic                  b_wr_en,
    output logic                  b_rd_en,
    output logic [DW-1:0]         b_din,
    input  logic [DW-1:0]         b_dout
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        ACK   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               b_wr_en_q, b_wr_en_d;
    logic               b_rd_en_q, b_rd_en_d;
    logic [DW-1:0]      b_din_q, b_din_d;
    logic               we_q, we_d;

    logic               win_found_c;
    logic [IW-1:0]      win_idx_c;
    logic [DW-1:0]      wslice_c [N_REQ];

`ifdef B_REG_ARB_RR_EN
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      idx_q, idx_d;
`endif

    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_wslice
        assign wslice_c[g] = wdata[g*int'(DW) +: int'(DW)];
    end

    // Winner: first set req bit scanning upward from the pointer, wrapping.
    always_comb begin
        int unsigned base;
        int unsigned pos;
        win_found_c = 1'b0;
        win_idx_c   = '0;
`ifdef B_REG_ARB_RR_EN
        base = 32'(ptr_q);
`else
        base = 0;
`endif
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = base + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!win_found_c && req[IW'(pos)]) begin
                win_found_c = 1'b1;
                win_idx_c   = IW'(pos);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        rdata_d   = rdata_q;
        b_wr_en_d = 1'b0;
        b_rd_en_d = 1'b0;
        b_din_d   = b_din_q;
        we_d      = we_q;
`ifdef B_REG_ARB_RR_EN
        ptr_d     = ptr_q;
        idx_d     = idx_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    state_d   = ISSUE;
                    gnt_d     = N_REQ'(1) << win_idx_c;
                    we_d      = we[win_idx_c];
                    b_wr_en_d = we[win_idx_c];
                    b_rd_en_d = ~we[win_idx_c];
                    if (we[win_idx_c]) begin
                        b_din_d = wslice_c[win_idx_c];
                    end
`ifdef B_REG_ARB_RR_EN
                    idx_d     = win_idx_c;
`endif
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = ACK;
                    ack_d   = gnt_q;
                end else begin
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                state_d = ACK;
                rdata_d = b_dout;
                ack_d   = gnt_q;
            end
            ACK: begin
                state_d = IDLE;
                gnt_d   = '0;
`ifdef B_REG_ARB_RR_EN
                ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : IW'(idx_q + 1'b1);
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge b_reg_arb_clk) begin
        if (b_reg_arb_rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            b_wr_en_q <= 1'b0;
            b_rd_en_q <= 1'b0;
            b_din_q   <= '0;
            we_q      <= 1'b0;
`ifdef B_REG_ARB_RR_EN
            ptr_q     <= '0;
            idx_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            b_wr_en_q <= b_wr_en_d;
            b_rd_en_q <= b_rd_en_d;
            b_din_q   <= b_din_d;
            we_q      <= we_d;
`ifdef B_REG_ARB_RR_EN
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign b_wr_en = b_wr_en_q;
    assign b_rd_en = b_rd_en_q;
    assign b_din   = b_din_q;

endmodule

// File: tb/tb_b_reg_arbiter.sv
// Self-checking bench for b_reg_arbiter: table of transactions plus reset and withdrawal sequences.
// Expectations follow B_REG_ARB_RR_EN when it is defined for the build.
module tb_b_reg_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   we = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt, ack;
    logic [W-1:0]   rdata, b_din;
    logic           busy, b_wr_en, b_rd_en;
    logic [W-1:0]   b_dout = '0;
    logic [W-1:0]   breg = '0;

    int n_chk  = 0;
    int n_fail = 0;

    b_reg_arbiter #(.N_REQ(N), .DW(W)) dut (
        .b_reg_arb_clk (clk),
        .b_reg_arb_rst (rst),
        .req           (req),
        .we            (we),
        .wdata         (wdata),
        .gnt           (gnt),
        .ack           (ack),
        .rdata         (rdata),
        .busy          (busy),
        .b_wr_en       (b_wr_en),
        .b_rd_en       (b_rd_en),
        .b_din         (b_din),
        .b_dout        (b_dout)
    );

    always #5 clk = ~clk;

    // B register model: write on enable, registered read output.
    always @(posedge clk) begin
        if (b_wr_en) breg <= b_din;
        if (b_rd_en) b_dout <= breg;
    end

    typedef struct {
        logic [3:0]  rq;
        logic [3:0]  w;
        logic [15:0] d;
        int          win;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'(1 << i);
    endfunction

    task automatic run_txn(input vec_t v, input string nm);
        logic wr;
        wr  = v.w[v.win];
        req = v.rq;
        we  = v.w;
        for (int i = 0; i < N; i++) wdata[i*W +: W] = (i == v.win) ? v.d : ~v.d;
        @(posedge clk);
        @(negedge clk);
        chk({nm, " s1 gnt"}, 32'(gnt), 32'(oh(v.win)));
        chk({nm, " s1 busy"}, 32'(busy), 32'd1);
        chk({nm, " s1 wr_en"}, 32'(b_wr_en), 32'(wr));
        chk({nm, " s1 rd_en"}, 32'(b_rd_en), 32'(!wr));
        chk({nm, " s1 ack"}, 32'(ack), 32'd0);
        if (wr) chk({nm, " s1 b_din"}, 32'(b_din), 32'(v.d));
        we    = ~we;
        wdata = ~wdata;
        @(negedge clk);
        chk({nm, " s2 wr_en"}, 32'(b_wr_en), 32'd0);
        chk({nm, " s2 rd_en"}, 32'(b_rd_en), 32'd0);
        chk({nm, " s2 gnt"}, 32'(gnt), 32'(oh(v.win)));
        if (wr) begin
            chk({nm, " s2 ack"}, 32'(ack), 32'(oh(v.win)));
            req[v.win] = 1'b0;
        end else begin
            chk({nm, " s2 ack"}, 32'(ack), 32'd0);
            @(negedge clk);
            chk({nm, " s3 ack"}, 32'(ack), 32'(oh(v.win)));
            chk({nm, " s3 rdata"}, 32'(rdata), 32'(v.exp_rd));
            req[v.win] = 1'b0;
        end
        @(negedge clk);
        chk({nm, " end ack"}, 32'(ack), 32'd0);
        chk({nm, " end gnt"}, 32'(gnt), 32'd0);
        chk({nm, " end busy"}, 32'(busy), 32'd0);
        if (!wr) chk({nm, " end rdata held"}, 32'(rdata), 32'(v.exp_rd));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " gnt"}, 32'(gnt), 32'd0);
        chk({nm, " ack"}, 32'(ack), 32'd0);
        chk({nm, " rdata"}, 32'(rdata), 32'd0);
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " wr_en"}, 32'(b_wr_en), 32'd0);
        chk({nm, " rd_en"}, 32'(b_rd_en), 32'd0);
        chk({nm, " b_din"}, 32'(b_din), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // rq, w, d, win, exp_rd
        tbl[0]  = '{4'b0010, 4'b0010, 16'h5A5A, 1, 16'h0000};
        tbl[1]  = '{4'b0001, 4'b0001, 16'hA5A5, 0, 16'h0000};
        tbl[2]  = '{4'b0100, 4'b0100, 16'h1234, 2, 16'h0000};
        tbl[3]  = '{4'b1000, 4'b0000, 16'h0000, 3, 16'h1234};
        tbl[4]  = '{4'b1111, 4'b1111, 16'h0000, 0, 16'h0000};
`ifdef B_REG_ARB_RR_EN
        tbl[5]  = '{4'b1111, 4'b1111, 16'h0001, 1, 16'h0000};
`else
        tbl[5]  = '{4'b1111, 4'b1111, 16'h0001, 0, 16'h0000};
`endif
        tbl[6]  = '{4'b1100, 4'b1100, 16'h0002, 2, 16'h0000};
        tbl[7]  = '{4'b1000, 4'b1000, 16'h0003, 3, 16'h0000};
        tbl[8]  = '{4'b0010, 4'b0000, 16'h0000, 1, 16'h0003};
        tbl[9]  = '{4'b0100, 4'b0100, 16'h7777, 2, 16'h0000};
        tbl[10] = '{4'b0011, 4'b0011, 16'h1111, 0, 16'h0000};
        tbl[11] = '{4'b0010, 4'b0010, 16'h2222, 1, 16'h0000};
`ifdef B_REG_ARB_RR_EN
        tbl[12] = '{4'b1111, 4'b1111, 16'h3333, 2, 16'h0000};
`else
        tbl[12] = '{4'b1111, 4'b1111, 16'h3333, 0, 16'h0000};
`endif
        tbl[13] = '{4'b0001, 4'b0000, 16'h0000, 0, 16'h3333};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Read by requester 3 interrupted by a 2-cycle reset during ISSUE.
        req = 4'b1000;
        we  = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        chk("mid-read rd_en", 32'(b_rd_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rst cyc1");
        @(negedge clk);
        chk_all_zero("rst cyc2");
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        chk("post-rst ack", 32'(ack), 32'd0);
        chk("post-rst busy", 32'(busy), 32'd0);

        for (int k = 0; k < 14; k++) begin
            run_txn(tbl[k], $sformatf("row%0d", k));
        end

        // Requester 1 withdraws req during ISSUE of a write.
        req = 4'b0010;
        we  = 4'b0010;
        wdata = '0;
        wdata[1*W +: W] = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        chk("wd wr_en", 32'(b_wr_en), 32'd1);
        chk("wd b_din", 32'(b_din), 32'hBEEF);
        req = '0;
        @(negedge clk);
        chk("wd ack", 32'(ack), 32'b0010);
        @(negedge clk);
        chk("wd busy", 32'(busy), 32'd0);
        chk("wd gnt", 32'(gnt), 32'd0);
        chk("wd ack off", 32'(ack), 32'd0);
        v = '{4'b1000, 4'b0000, 16'h0000, 3, 16'hBEEF};
        run_txn(v, "wd readback");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
